// File: rtl/sya_pkg.sv
// Shared state encoding and defaults for the systolic-array row sequencer.
package sya_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 16;
  localparam int unsigned ST_W          = 3;

  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_RUN   = 3'd1;
  localparam logic [ST_W-1:0] ST_FLUSH = 3'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sya_col_tracker.sv
// Follows the acc_reset wavefront across the row and names the column whose
// quantised result is on out_fm in each advancing cycle.
module sya_col_tracker #(
  parameter int unsigned NUM_PE    = 16,
  parameter int unsigned COL_WIDTH = $clog2(NUM_PE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_arm,
  input  logic                 i_adv,
  output logic                 o_fm_vld,
  output logic [COL_WIDTH-1:0] o_fm_col,
  output logic                 o_armed
);

  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(NUM_PE - 1);

  logic                 r_armed;
  logic [COL_WIDTH-1:0] r_col;

  // A new arm restarts at column 0 even if the previous sweep ends this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
      r_col   <= '0;
    end else if (i_adv) begin
      if (i_arm) begin
        r_armed <= 1'b1;
        r_col   <= '0;
      end else if (r_armed) begin
        if (r_col == COL_LAST) begin
          r_armed <= 1'b0;
          r_col   <= '0;
        end else begin
          r_col <= r_col + COL_WIDTH'(1);
        end
      end
    end
  end

  assign o_fm_vld = r_armed & i_adv;
  assign o_fm_col = r_col;
  assign o_armed  = r_armed;

endmodule

// File: rtl/sya_row_ctrl.sv
// Left-edge sequencer for one systolic PE row: issues operands, injects
// acc_reset wavefronts with minimum spacing, and tracks finished columns.
module sya_row_ctrl
  import sya_pkg::*;
#(
  parameter int unsigned NUM_PE    = 16,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned COL_WIDTH = $clog2(NUM_PE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_vld,
  output logic                 cfg_rdy,
  input  logic [CNT_WIDTH-1:0] cfg_k,
  input  logic [CNT_WIDTH-1:0] cfg_tiles,
  input  logic                 op_vld,
  output logic                 op_pop,
  input  logic                 out_stall,
  output logic                 row_vld,
  output logic                 row_rdy,
  output logic                 row_acc_reset,
  output logic                 out_fm_vld,
  output logic [COL_WIDTH-1:0] out_fm_col,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned          SPC_W   = $clog2(NUM_PE + 1);
  localparam logic [SPC_W-1:0]     SPC_MIN = SPC_W'(NUM_PE);

  logic [ST_W-1:0]      r_state;
  logic [ST_W-1:0]      w_state_nxt;
  logic [CNT_WIDTH-1:0] r_k;
  logic [CNT_WIDTH-1:0] r_t;
  logic [CNT_WIDTH-1:0] r_k_cnt;
  logic [CNT_WIDTH-1:0] r_t_cnt;
  logic [SPC_W-1:0]     r_spc_cnt;

  logic w_adv;
  logic w_k_first;
  logic w_k_last;
  logic w_t_last;
  logic w_gap;
  logic w_issue;
  logic w_flush;
  logic w_acc_reset;
  logic w_arm;
  logic w_armed;

  assign w_adv     = ~out_stall;
  assign w_k_first = (r_k_cnt == '0);
  assign w_k_last  = (r_k_cnt == r_k - CNT_WIDTH'(1));
  assign w_t_last  = (r_t_cnt == r_t - CNT_WIDTH'(1));
  // Hold a new tile back until the previous wavefront has cleared the row.
  assign w_gap     = w_k_first & (r_spc_cnt < SPC_MIN) & (r_t_cnt != '0);
  assign w_issue   = (r_state == ST_RUN) & op_vld & w_adv & ~w_gap;
  assign w_flush   = (r_state == ST_FLUSH) & w_adv & (r_spc_cnt >= SPC_MIN);
  assign w_acc_reset = (w_issue & w_k_first) | w_flush;
  // The job's first reset has no prior tile to read out.
  assign w_arm     = w_flush | (w_issue & w_k_first & (r_t_cnt != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    cfg_rdy       = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    op_pop        = w_issue;
    row_vld       = w_issue;
    row_acc_reset = w_acc_reset;
    row_rdy       = w_adv;
    case (r_state)
      ST_IDLE: begin
        cfg_rdy = 1'b1;
        busy    = 1'b0;
        if (cfg_vld) w_state_nxt = (cfg_tiles == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN:   if (w_issue && w_k_last && w_t_last) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (w_flush) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!w_armed) w_state_nxt = ST_DONE;
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Job parameters, element/tile counters and reset-spacing counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_t       <= '0;
      r_k_cnt   <= '0;
      r_t_cnt   <= '0;
      r_spc_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (cfg_vld) begin
        r_k       <= (cfg_k == '0) ? CNT_WIDTH'(1) : cfg_k;
        r_t       <= cfg_tiles;
        r_k_cnt   <= '0;
        r_t_cnt   <= '0;
        r_spc_cnt <= '0;
      end
    end else begin
      if (w_issue) begin
        if (w_k_last) begin
          r_k_cnt <= '0;
          r_t_cnt <= r_t_cnt + CNT_WIDTH'(1);
        end else begin
          r_k_cnt <= r_k_cnt + CNT_WIDTH'(1);
        end
      end
      if (w_acc_reset)                        r_spc_cnt <= SPC_W'(1);
      else if (w_adv && r_spc_cnt < SPC_MIN) r_spc_cnt <= r_spc_cnt + SPC_W'(1);
    end
  end

  sya_col_tracker #(
    .NUM_PE   (NUM_PE),
    .COL_WIDTH(COL_WIDTH)
  ) u_col_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_arm   (w_arm),
    .i_adv   (w_adv),
    .o_fm_vld(out_fm_vld),
    .o_fm_col(out_fm_col),
    .o_armed (w_armed)
  );

endmodule

// File: tb/tb_sya_row_ctrl.sv
// Randomised and directed bench for sya_row_ctrl against a pop-count based
// reference model of the row sequencing rules.
module tb_sya_row_ctrl;

  localparam int unsigned NUM_PE = 4;
  localparam int unsigned CW     = 16;
  localparam int          BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cfg_vld = 1'b0;
  logic          cfg_rdy;
  logic [CW-1:0] cfg_k = '0;
  logic [CW-1:0] cfg_tiles = '0;
  logic          op_vld = 1'b0;
  logic          op_pop;
  logic          out_stall = 1'b0;
  logic          row_vld;
  logic          row_rdy;
  logic          row_acc_reset;
  logic          out_fm_vld;
  logic [1:0]    out_fm_col;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  sya_row_ctrl #(.NUM_PE(NUM_PE), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_vld      (cfg_vld),
    .cfg_rdy      (cfg_rdy),
    .cfg_k        (cfg_k),
    .cfg_tiles    (cfg_tiles),
    .op_vld       (op_vld),
    .op_pop       (op_pop),
    .out_stall    (out_stall),
    .row_vld      (row_vld),
    .row_rdy      (row_rdy),
    .row_acc_reset(row_acc_reset),
    .out_fm_vld   (out_fm_vld),
    .out_fm_col   (out_fm_col),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask

  // Runs one job; the model tracks pops, advancing cycles since the last
  // reset and the expected column sweep, and checks every cycle.
  task automatic run_job(input int k, input int t, input int vld_pct, input bit tog,
                         input int ss, input int sl, input int stall_pct,
                         output int pops_o, output int done_rel_o);
    int  kk, total, pops, since, col, done_due, rel;
    bit  flushed, armed, vld, stall, adv, e_issue, e_flush, e_rst, e_arm, e_fm, e_done, fin;
    kk = (k == 0) ? 1 : k;
    total = kk * t;
    pops = 0; since = 0; col = 0; flushed = 0; armed = 0;
    done_due = (t == 0) ? 0 : -1;
    pops_o = 0; done_rel_o = -1;
    @(negedge clk);
    cfg_vld = 1'b1; cfg_k = CW'(k); cfg_tiles = CW'(t); op_vld = 1'b0; out_stall = 1'b0;
    #1 chk("cfg_rdy_idle", 32'(cfg_rdy), 32'(1));
    @(negedge clk);
    cfg_vld = 1'b0;
    rel = 0; fin = 0;
    while (!fin) begin
      vld   = tog ? (rel % 2 == 0) : (int'($urandom_range(99)) < vld_pct);
      stall = (rel >= ss && rel < ss + sl) || (int'($urandom_range(99)) < stall_pct);
      op_vld = vld; out_stall = stall; adv = !stall;
      #1;
      e_issue = (pops < total) && vld && adv &&
                !((pops % kk == 0) && (pops >= kk) && (since < int'(NUM_PE)));
      e_flush = (t > 0) && (pops == total) && !flushed && adv && (since >= int'(NUM_PE));
      e_rst   = (e_issue && (pops % kk == 0)) || e_flush;
      e_arm   = e_flush || (e_issue && (pops % kk == 0) && (pops >= kk));
      e_fm    = armed && adv;
      e_done  = (done_due >= 0) && (rel == done_due);
      chk("op_pop", 32'(op_pop), 32'(e_issue));
      chk("row_vld", 32'(row_vld), 32'(e_issue));
      chk("row_acc_reset", 32'(row_acc_reset), 32'(e_rst));
      chk("row_rdy", 32'(row_rdy), 32'(adv));
      chk("out_fm_vld", 32'(out_fm_vld), 32'(e_fm));
      if (e_fm) chk("out_fm_col", 32'(out_fm_col), 32'(col));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(1));
      if (op_pop) pops_o++;
      if (done) done_rel_o = rel;
      if (e_issue) pops++;
      if (e_rst) since = 1;
      else if (adv && since < int'(NUM_PE)) since++;
      if (e_flush) flushed = 1;
      if (adv) begin
        if (e_arm) begin
          armed = 1; col = 0;
        end else if (armed) begin
          col++;
          if (col == int'(NUM_PE)) begin
            armed = 0; col = 0;
            if (flushed) done_due = rel + 2;
          end
        end
      end
      if (e_done) fin = 1;
      else if (rel >= BUDGET) begin
        chk("job_timeout", 32'(rel), 32'(done_due));
        fin = 1;
      end
      @(negedge clk);
      rel++;
    end
    op_vld = 1'b0; out_stall = 1'b0;
    #1;
    chk("cfg_rdy_after", 32'(cfg_rdy), 32'(1));
    chk("busy_after", 32'(busy), 32'(0));
  endtask

  initial begin
    int p, d;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cfg_rdy", 32'(cfg_rdy), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_op_pop", 32'(op_pop), 32'(0));
    chk("rst_row_vld", 32'(row_vld), 32'(0));
    chk("rst_acc_reset", 32'(row_acc_reset), 32'(0));
    chk("rst_fm_vld", 32'(out_fm_vld), 32'(0));
    chk("rst_fm_col", 32'(out_fm_col), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_job(6, 2, 100, 1'b0, 1000, 0, 0, p, d);
    chk("k6t2_pops", 32'(p), 32'(12));
    chk("k6t2_done_cycle", 32'(d), 32'(18));

    run_job(2, 3, 100, 1'b0, 1000, 0, 0, p, d);
    chk("k2t3_pops", 32'(p), 32'(6));
    chk("k2t3_done_cycle", 32'(d), 32'(18));

    run_job(4, 1, 100, 1'b1, 1000, 0, 0, p, d);
    chk("toggle_pops", 32'(p), 32'(4));

    run_job(6, 2, 100, 1'b0, 14, 3, 0, p, d);
    chk("drain_stall_pops", 32'(p), 32'(12));
    chk("drain_stall_done", 32'(d), 32'(21));

    run_job(5, 0, 100, 1'b0, 1000, 0, 0, p, d);
    chk("empty_pops", 32'(p), 32'(0));
    chk("empty_done", 32'(d), 32'(0));

    run_job(0, 1, 100, 1'b0, 1000, 0, 0, p, d);
    chk("k0_pops", 32'(p), 32'(1));
    chk("k0_done", 32'(d), 32'(10));

    run_job(1, 3, 100, 1'b0, 1000, 0, 0, p, d);
    chk("k1t3_pops", 32'(p), 32'(3));

    // Abort mid-job with rst_n, then confirm a fresh job runs cleanly.
    @(negedge clk);
    cfg_vld = 1'b1; cfg_k = CW'(6); cfg_tiles = CW'(2); op_vld = 1'b1; out_stall = 1'b0;
    @(negedge clk);
    cfg_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_pre_pop", 32'(op_pop), 32'(1));
    chk("abort_pre_busy", 32'(busy), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_op_pop", 32'(op_pop), 32'(0));
    chk("abort_row_vld", 32'(row_vld), 32'(0));
    chk("abort_acc_reset", 32'(row_acc_reset), 32'(0));
    chk("abort_fm_vld", 32'(out_fm_vld), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_cfg_rdy", 32'(cfg_rdy), 32'(1));
    @(negedge clk);
    rst_n = 1'b1; op_vld = 1'b0;
    run_job(3, 2, 100, 1'b0, 1000, 0, 0, p, d);
    chk("post_abort_pops", 32'(p), 32'(6));

    for (int j = 0; j < 12; j++) begin
      int rk, rt;
      rk = int'($urandom_range(7));
      rt = int'($urandom_range(3));
      run_job(rk, rt, 40 + int'($urandom_range(60)), 1'b0, 1000, 0,
              int'($urandom_range(30)), p, d);
      chk("rand_pops", 32'(p), 32'(((rk == 0) ? 1 : rk) * rt));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
